rd_color: RTL and testbench

Read-side counterpart of the colour-bar frame writer. Once the frame in DDR is complete, it fetches the 1280x720 frame line by line over the MIG user read-request interface. It forwards each 128-bit beat into the display line FIFO and throttles requests so the FIFO can never overflow. It sits between the DDR user-interface arbiter and the HDMI pixel-unpacking FIFO.

---
 rtl/mig_color_pkg.sv | 20 ++
 rtl/rd_color.sv | 187 ++++++++++++++++++
 tb/tb_rd_color.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_color_pkg.sv
// Constants and types shared by the colour-bar frame writer and reader.
package mig_color_pkg;

    // Frame geometry and DDR user-interface sizing.
    localparam int unsigned H_PIXELS       = 1280;
    localparam int unsigned V_LINES        = 720;
    localparam int unsigned DATA_W         = 128;
    localparam int unsigned ADDR_W         = 28;
    localparam int unsigned BEATS_PER_LINE = H_PIXELS * 32 / DATA_W;
    localparam int unsigned LINE_ADDR_STEP = 2560;

    // Read-side fetch FSM.
    typedef enum logic [1:0] {
        StIdle,
        StWaitSpace,
        StReq,
        StData
    } rd_state_e;

endpackage

// File: rtl/rd_color.sv
// Frame reader: fetches the written frame line by line from DDR and feeds the
// display line FIFO, issuing a line request only when the FIFO has room for it.
module rd_color #(
    parameter int unsigned V_LINES        = mig_color_pkg::V_LINES,
    parameter int unsigned BEATS_PER_LINE = mig_color_pkg::BEATS_PER_LINE,
    parameter int unsigned LINE_ADDR_STEP = mig_color_pkg::LINE_ADDR_STEP,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned FIFO_DEPTH     = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ui_wr_done,
    input  logic         frame_sync,
    output logic         rd_req,
    output logic [27:0]  rd_req_addr,
    output logic [15:0]  rd_length,
    input  logic         rd_busy,
    input  logic [127:0] rd_data,
    input  logic         rd_data_valid,
    input  logic         rd_done,
    input  logic [10:0]  fifo_wr_count,
    output logic         fifo_wr_en,
    output logic [127:0] fifo_wr_data,
    output logic         rd_err
);

    import mig_color_pkg::*;

    localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrStep  = ADDR_W'(LINE_ADDR_STEP);
    localparam logic [11:0]       DepthW    = 12'(FIFO_DEPTH);
    localparam logic [11:0]       BeatsW12  = 12'(BEATS_PER_LINE);
    localparam logic [9:0]        BeatsW10  = 10'(BEATS_PER_LINE);
    localparam logic [8:0]        BeatsW9   = 9'(BEATS_PER_LINE);
    localparam logic [9:0]        LastLine  = 10'(V_LINES - 1);

    rd_state_e         state_q, state_d;
    logic [9:0]        line_q, line_d;
    logic [8:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d;
    logic              err_q, err_d;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [11:0]       free_space;
    logic              space_ok;
    logic [9:0]        done_cnt;
    logic              in_data;

    // Free FIFO room and the gate for issuing the next line request.
    always_comb begin
        free_space = DepthW - {1'b0, fifo_wr_count};
        space_ok   = (free_space >= BeatsW12) && !rd_busy && ui_wr_done;
        in_data    = (state_q == StData);
        // Beats of this burst including one arriving together with rd_done.
        done_cnt   = {1'b0, beat_q} + {9'd0, rd_data_valid};
    end

    // Fetch FSM next-state, line/beat counters, address and error flag.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        req_d   = 1'b0;
        err_d   = err_q;

        // Data with no burst outstanding is dropped and flagged.
        if (rd_data_valid && !in_data) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_sync && ui_wr_done) begin
                    line_d  = 10'd0;
                    beat_d  = 9'd0;
                    addr_d  = BaseAddr;
                    state_d = StWaitSpace;
                end
            end

            StWaitSpace: begin
                if (frame_sync) begin
                    line_d = 10'd0;
                    addr_d = BaseAddr;
                end else if (space_ok) begin
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end

            StReq: begin
                // The request is already out, so the burst must be drained
                // before restarting; defer the sync.
                if (frame_sync) begin
                    pend_d = 1'b1;
                end
                beat_d  = 9'd0;
                state_d = StData;
            end

            StData: begin
                if (frame_sync) begin
                    pend_d = 1'b1;
                end
                if (rd_data_valid) begin
                    if (beat_q >= BeatsW9) begin
                        err_d = 1'b1;
                    end
                    if (beat_q != 9'h1ff) begin
                        beat_d = beat_q + 9'd1;
                    end
                end
                if (rd_done) begin
                    if (done_cnt != BeatsW10) begin
                        err_d = 1'b1;
                    end
                    beat_d = 9'd0;
                    if (pend_q || frame_sync) begin
                        pend_d  = 1'b0;
                        line_d  = 10'd0;
                        addr_d  = BaseAddr;
                        state_d = StWaitSpace;
                    end else if (line_q == LastLine) begin
                        line_d  = 10'd0;
                        addr_d  = BaseAddr;
                        state_d = StIdle;
                    end else begin
                        line_d  = line_q + 10'd1;
                        addr_d  = addr_q + AddrStep;
                        state_d = StWaitSpace;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            line_q  <= 10'd0;
            beat_q  <= 9'd0;
            addr_q  <= BaseAddr;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // Forward read beats to the FIFO with a fixed one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= rd_data_valid && in_data;
            if (rd_data_valid && in_data) begin
                wr_data_q <= rd_data;
            end
        end
    end

    assign rd_req       = req_q;
    assign rd_req_addr  = addr_q;
    assign rd_length    = 16'(BEATS_PER_LINE);
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign rd_err       = err_q;

endmodule

// File: tb/tb_rd_color.sv
// Bench for rd_color: table-driven backpressure vectors, scripted multi-line
// sequences and a scoreboard on the FIFO write stream. Frame height is reduced
// so a whole frame fits in a short run.
module tb_rd_color;

    localparam int TbLines = 12;
    localparam int Beats   = 320;
    localparam int Step    = 2560;

    logic         clk = 1'b0;
    logic         rst;
    logic         ui_wr_done;
    logic         frame_sync;
    logic         rd_req;
    logic [27:0]  rd_req_addr;
    logic [15:0]  rd_length;
    logic         rd_busy;
    logic [127:0] rd_data;
    logic         rd_data_valid;
    logic         rd_done;
    logic [10:0]  fifo_wr_count;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic         rd_err;

    rd_color #(
        .V_LINES(TbLines)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ui_wr_done   (ui_wr_done),
        .frame_sync   (frame_sync),
        .rd_req       (rd_req),
        .rd_req_addr  (rd_req_addr),
        .rd_length    (rd_length),
        .rd_busy      (rd_busy),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .rd_done      (rd_done),
        .fifo_wr_count(fifo_wr_count),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_fail = 0;
    int           req_cnt = 0;
    logic [127:0] sb[$];
    logic [127:0] mon_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every forwarded beat must match the oldest driven beat.
    always @(negedge clk) begin
        if (rd_req) req_cnt++;
        if (!rst && fifo_wr_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL fifo_extra: got write %0h expected no write", fifo_wr_data);
            end else begin
                mon_exp = sb.pop_front();
                check("fifo_data", fifo_wr_data, mon_exp);
            end
        end
    end

    task automatic pulse_sync();
        @(posedge clk); #1 frame_sync = 1'b1;
        @(posedge clk); #1 frame_sync = 1'b0;
    endtask

    task automatic wait_req(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (rd_req) seen = 1'b1;
        end
    endtask

    // Called at the negedge where rd_req was seen: check it, then play a burst.
    task automatic serve(input int line, input int nbeats, input int sync_at, input bit do_done);
        logic [127:0] d;
        check("req_addr", {100'd0, rd_req_addr}, 128'(line * Step));
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("req_one_cycle", {127'd0, rd_req}, 128'd0);
            d = {32'(line), 32'(i), $urandom, $urandom};
            rd_data_valid = 1'b1;
            rd_data       = d;
            sb.push_back(d);
            frame_sync    = (i == sync_at);
        end
        @(posedge clk); #1;
        rd_data_valid = 1'b0;
        frame_sync    = 1'b0;
        if (do_done) begin
            rd_done = 1'b1;
            @(posedge clk); #1 rd_done = 1'b0;
        end
    endtask

    task automatic do_line(input int line, input int nbeats, input int sync_at);
        bit seen;
        wait_req(50, seen);
        check("req_seen", {127'd0, seen}, 128'd1);
        if (seen) serve(line, nbeats, sync_at, 1'b1);
    endtask

    typedef struct {
        logic [10:0] count;
        logic        busy;
        logic        exp_req;
    } bp_vec_t;

    initial begin
        bp_vec_t vecs[8];
        bit      seen;
        int      req0;
        int      tl;

        vecs[0] = '{11'd1024, 1'b0, 1'b0};
        vecs[1] = '{11'd800,  1'b0, 1'b0};
        vecs[2] = '{11'd705,  1'b0, 1'b0};
        vecs[3] = '{11'd704,  1'b1, 1'b0};
        vecs[4] = '{11'd704,  1'b0, 1'b1};
        vecs[5] = '{11'd0,    1'b0, 1'b1};
        vecs[6] = '{11'd1000, 1'b1, 1'b0};
        vecs[7] = '{11'd100,  1'b0, 1'b1};

        rst = 1'b1; ui_wr_done = 1'b0; frame_sync = 1'b0; rd_busy = 1'b0;
        rd_data = '0; rd_data_valid = 1'b0; rd_done = 1'b0; fifo_wr_count = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",    {127'd0, rd_req},      128'd0);
        check("rst_addr",   {100'd0, rd_req_addr}, 128'd0);
        check("rst_wr_en",  {127'd0, fifo_wr_en},  128'd0);
        check("rst_wr_dat", fifo_wr_data,          128'd0);
        check("rst_err",    {127'd0, rd_err},      128'd0);
        check("rd_length",  {112'd0, rd_length},   128'd320);
        @(posedge clk); #1 rst = 1'b0;

        // Gating: syncs while the frame is not written must not fetch.
        req0 = req_cnt;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1 frame_sync = (c % 97 == 0);
        end
        frame_sync = 1'b0;
        check("gate_no_req", 128'(req_cnt - req0), 128'd0);

        // Backpressure table, starting in WAIT_SPACE at line 0.
        ui_wr_done = 1'b1;
        fifo_wr_count = 11'd1024;
        pulse_sync();
        tl = 0;
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            fifo_wr_count = vecs[v].count;
            rd_busy       = vecs[v].busy;
            wait_req(4, seen);
            check($sformatf("bp_vec%0d", v), {127'd0, seen}, {127'd0, vecs[v].exp_req});
            if (seen) begin
                serve(tl, Beats, -1, 1'b1);
                fifo_wr_count = 11'd1024;
                tl++;
            end
        end
        fifo_wr_count = 11'd0;
        rd_busy = 1'b0;

        // Lines 3 and 4, then a sync in the middle of line 5.
        do_line(3, Beats, -1);
        do_line(4, Beats, -1);
        do_line(5, Beats, 100);

        // Restarted frame, run to completion.
        for (int l = 0; l < TbLines; l++) do_line(l, Beats, -1);
        wait_req(20, seen);
        check("idle_no_req", {127'd0, seen},       128'd0);
        check("idle_addr",   {100'd0, rd_req_addr}, 128'd0);
        check("frame_err",   {127'd0, rd_err},      128'd0);
        check("sb_drained",  128'(sb.size()),       128'd0);

        // Sync while blocked in WAIT_SPACE at line 2 restarts at line 0.
        pulse_sync();
        do_line(0, Beats, -1);
        do_line(1, Beats, -1);
        fifo_wr_count = 11'd1024;
        wait_req(6, seen);
        check("ws_blocked", {127'd0, seen}, 128'd0);
        pulse_sync();
        fifo_wr_count = 11'd0;
        do_line(0, Beats, -1);
        do_line(1, Beats, -1);
        do_line(2, Beats, -1);

        // Reset at beat 50 of line 3, with beats still arriving during reset.
        wait_req(50, seen);
        check("req_seen", {127'd0, seen}, 128'd1);
        if (seen) serve(3, 50, -1, 1'b0);
        rst = 1'b1;
        sb.delete();
        rd_data_valid = 1'b1;
        rd_data = {4{32'hdead_beef}};
        @(negedge clk);
        check("mid_rst_req",   {127'd0, rd_req},      128'd0);
        check("mid_rst_addr",  {100'd0, rd_req_addr}, 128'd0);
        check("mid_rst_wr_en", {127'd0, fifo_wr_en},  128'd0);
        check("mid_rst_err",   {127'd0, rd_err},      128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rd_data_valid = 1'b0;
        @(negedge clk);
        check("post_rst_err", {127'd0, rd_err}, 128'd0);

        // A late beat in IDLE is flagged and dropped.
        @(posedge clk); #1 rd_data_valid = 1'b1;
        @(posedge clk); #1 rd_data_valid = 1'b0;
        @(negedge clk);
        check("idle_beat_err",  {127'd0, rd_err},     128'd1);
        check("idle_beat_drop", {127'd0, fifo_wr_en}, 128'd0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("err_cleared", {127'd0, rd_err}, 128'd0);

        // Restart from address 0, then a short burst on line 1.
        pulse_sync();
        do_line(0, Beats, -1);
        do_line(1, Beats - 1, -1);
        @(negedge clk);
        check("short_err", {127'd0, rd_err}, 128'd1);
        do_line(2, Beats, -1);
        check("err_sticky", {127'd0, rd_err}, 128'd1);

        repeat (4) @(posedge clk);
        check("sb_final", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
